// File: rtl/flop_pkg.sv
// flop_pkg: shared sizing helpers and parameter checks for pipe/fifo blocks.
package flop_pkg;
  function automatic int cnt_w(input int depth);
    return $clog2(depth + 1);
  endfunction
  function automatic bit params_ok(input int width, input int depth);
    return (width >= 1) && (depth >= 1);
  endfunction
endpackage

// File: rtl/flop_stage.sv
// flop_stage: one data register plus valid bit with reset > clear > advance > hold priority.
module flop_stage #(
  parameter int WIDTH = 8,
  parameter logic [WIDTH-1:0] RST_VAL = '0
) (
  input  logic             CK,
  input  logic             R,
  input  logic             CLR,
  input  logic             EN,
  input  logic [WIDTH-1:0] D,
  input  logic             DV,
  output logic [WIDTH-1:0] Q,
  output logic             QV
);
  // Invalid beats carry RST_VAL so bubbles never leak stale data downstream.
  always_ff @(posedge CK or posedge R)
    if (R) begin
      Q  <= RST_VAL;
      QV <= 1'b0;
    end else if (CLR) begin
      Q  <= RST_VAL;
      QV <= 1'b0;
    end else if (EN) begin
      Q  <= DV ? D : RST_VAL;
      QV <= DV;
    end
endmodule

// File: rtl/flop_pipe.sv
// flop_pipe: stallable DEPTH-stage WIDTH-bit delay line with per-stage valids and occupancy count.
module flop_pipe import flop_pkg::*; #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 4,
  parameter logic [WIDTH-1:0] RST_VAL = '0
) (
  input  logic                      CK,
  input  logic                      R,
  input  logic                      CLR,
  input  logic                      EN,
  input  logic [WIDTH-1:0]          D,
  input  logic                      DV,
  output logic [WIDTH-1:0]          Q,
  output logic                      QV,
  output logic [cnt_w(DEPTH)-1:0]   CNT
);
  localparam int CW = cnt_w(DEPTH);
  if (!params_ok(WIDTH, DEPTH)) begin : g_bad_params
    $error("flop_pipe: WIDTH and DEPTH must both be at least 1");
  end
  logic [DEPTH:0][WIDTH-1:0] d_c;
  logic [DEPTH:0]            v_c;
  assign d_c[0] = D;
  assign v_c[0] = DV;
  for (genvar i = 0; i < DEPTH; i++) begin : g_stage
    flop_stage #(.WIDTH(WIDTH), .RST_VAL(RST_VAL)) u_stage (
      .CK (CK),
      .R  (R),
      .CLR(CLR),
      .EN (EN),
      .D  (d_c[i]),
      .DV (v_c[i]),
      .Q  (d_c[i+1]),
      .QV (v_c[i+1])
    );
  end
  assign Q  = d_c[DEPTH];
  assign QV = v_c[DEPTH];
  // A beat entering and one leaving on the same advance cancel, so a full pipe stays at DEPTH.
  always_ff @(posedge CK or posedge R)
    if (R) CNT <= '0;
    else if (CLR) CNT <= '0;
    else if (EN) CNT <= CNT + CW'(DV) - CW'(QV);
endmodule

// File: tb/tb_flop_pipe.sv
// tb_flop_pipe: directed and random stimulus checked against a queue model of the pipe.
module tb_flop_pipe;
  localparam int W = 8;
  localparam int N = 4;
  localparam logic [W-1:0] RV = 8'hA5;
  typedef struct packed {
    logic         v;
    logic [W-1:0] d;
  } beat_t;
  logic CK = 1'b0;
  logic R = 1'b0;
  logic CLR = 1'b0, EN = 1'b0, DV = 1'b0;
  logic [W-1:0] D = '0;
  logic [W-1:0] Q;
  logic QV;
  logic [2:0] CNT;
  logic CLR1 = 1'b0, EN1 = 1'b0, DV1 = 1'b0, D1 = 1'b0;
  logic Q1, QV1;
  logic [0:0] CNT1;
  logic exp1;
  int checks = 0;
  int errors = 0;
  beat_t m[$];
  flop_pipe #(.WIDTH(W), .DEPTH(N), .RST_VAL(RV)) dut (
    .CK(CK), .R(R), .CLR(CLR), .EN(EN), .D(D), .DV(DV), .Q(Q), .QV(QV), .CNT(CNT)
  );
  flop_pipe #(.WIDTH(1), .DEPTH(1), .RST_VAL(1'b0)) dut1 (
    .CK(CK), .R(R), .CLR(CLR1), .EN(EN1), .D(D1), .DV(DV1), .Q(Q1), .QV(QV1), .CNT(CNT1)
  );
  always #5 CK = ~CK;
  function automatic void model_reset();
    m.delete();
    repeat (N) m.push_back('{v: 1'b0, d: RV});
  endfunction
  function automatic void model_advance(input logic dv, input logic [W-1:0] d);
    beat_t b;
    b.v = dv;
    b.d = dv ? d : RV;
    m.push_front(b);
    void'(m.pop_back());
  endfunction
  function automatic int model_cnt();
    int c = 0;
    foreach (m[k]) c += int'(m[k].v);
    return c;
  endfunction
  task automatic check(input string tag);
    beat_t last;
    last = m[m.size()-1];
    checks++;
    assert (Q === last.d) else begin
      errors++;
      $error("FAIL %s Q observed=%h expected=%h", tag, Q, last.d);
    end
    checks++;
    assert (QV === last.v) else begin
      errors++;
      $error("FAIL %s QV observed=%b expected=%b", tag, QV, last.v);
    end
    checks++;
    assert (int'(CNT) === model_cnt()) else begin
      errors++;
      $error("FAIL %s CNT observed=%0d expected=%0d", tag, CNT, model_cnt());
    end
  endtask
  task automatic step(input string tag, input logic clr, input logic en, input logic dv,
                      input logic [W-1:0] d);
    CLR = clr;
    EN  = en;
    DV  = dv;
    D   = d;
    @(posedge CK);
    if (clr) model_reset();
    else if (en) model_advance(dv, d);
    #1;
    check(tag);
  endtask
  task automatic step1(input logic d);
    D1  = d;
    DV1 = 1'b1;
    EN1 = 1'b1;
    @(posedge CK);
    exp1 = d;
    #1;
    checks++;
    assert (Q1 === exp1 && QV1 === 1'b1 && CNT1 === 1'b1) else begin
      errors++;
      $error("FAIL depth1 Q/QV/CNT observed=%b/%b/%b expected=%b/1/1", Q1, QV1, CNT1, exp1);
    end
  endtask
  // Occupancy must match the model's valid count at every quiet point of the cycle.
  always @(negedge CK) begin
    checks++;
    assert (int'(CNT) === model_cnt()) else begin
      errors++;
      $error("FAIL popcount CNT observed=%0d expected=%0d", CNT, model_cnt());
    end
  end
  initial begin
    model_reset();
    #3 R = 1'b1;
    #1;
    check("async_reset");
    checks++;
    assert (Q1 === 1'b0 && QV1 === 1'b0 && CNT1 === 1'b0) else begin
      errors++;
      $error("FAIL depth1_reset Q/QV/CNT observed=%b/%b/%b expected=0/0/0", Q1, QV1, CNT1);
    end
    #3 R = 1'b0;
    for (int i = 1; i <= 8; i++) step("stream", 1'b0, 1'b1, 1'b1, W'(i));
    step("bubble_11", 1'b0, 1'b1, 1'b1, 8'h11);
    step("bubble_gap", 1'b0, 1'b1, 1'b0, W'($urandom));
    step("bubble_22", 1'b0, 1'b1, 1'b1, 8'h22);
    repeat (3) step("stall", 1'b0, 1'b0, 1'($urandom), W'($urandom));
    repeat (6) step("resume", 1'b0, 1'b1, 1'b0, W'($urandom));
    repeat (N) step("fill", 1'b0, 1'b1, 1'b1, W'($urandom_range(254)));
    step("clear", 1'b1, 1'b1, 1'b1, 8'hFF);
    repeat (N + 1) step("post_clear", 1'b0, 1'b1, 1'b0, 8'h00);
    for (int i = 0; i < 3; i++) step("inflight", 1'b0, 1'b1, 1'b1, W'(8'h40 + i));
    #1 R = 1'b1;
    model_reset();
    #1;
    check("mid_reset");
    @(posedge CK);
    #1 R = 1'b0;
    check("reset_hold");
    for (int i = 0; i < 6; i++) step("after_reset", 1'b0, 1'b1, 1'b1, W'(8'h31 + i));
    for (int i = 0; i < 300; i++)
      step("random", 1'($urandom_range(15) == 0), 1'($urandom_range(3) != 0),
           1'($urandom), W'($urandom));
    EN = 1'b0;
    for (int i = 0; i < 8; i++) step1(1'(i));
    @(negedge CK);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule

// File: doc/flop_pipe.md
# flop_pipe

Parametrised multi-bit pipeline register: a DEPTH-stage, WIDTH-bit delay line with per-stage valid bits, a global advance enable, a synchronous clear, and an occupancy count. It generalises the single-bit D flop of the cell library to a bus-wide, multi-stage element. Datapath blocks use it wherever a stallable fixed-latency delay with qualified data is needed.

## Interface
Parameters:
- WIDTH, 8, data width in bits; must be at least 1.
- DEPTH, 4, number of stages; must be at least 1, and DEPTH=0 is an elaboration error.
- RST_VAL, 0 (WIDTH bits), value loaded into every data stage on reset, on clear, and on an invalid advance.

Ports:
- CK, input, 1, clock; all state updates on the rising edge.
- R, input, 1, reset; asynchronous, active-high.
- CLR, input, 1, synchronous clear.
- EN, input, 1, advance enable; when 0 all stages hold.
- D, input, WIDTH, data into stage 0.
- DV, input, 1, valid qualifier for D.
- Q, output, WIDTH, data of stage DEPTH-1.
- QV, output, 1, valid of stage DEPTH-1.
- CNT, output, $clog2(DEPTH+1), number of valid stages.

## Operation
- Priority is R > CLR > EN > hold.
- R=1, asynchronous: every data stage = RST_VAL, every valid = 0, CNT = 0. Therefore Q = RST_VAL and QV = 0 immediately, with no clock needed.
- CLR=1 at an edge, R=0: same end state as reset. CLR wins over EN; D and DV are ignored.
- EN=1 at an edge, CLR=0:
  - stage[0] data is loaded with D if DV=1, else with RST_VAL.
  - v[0] is loaded with DV.
  - For i>0, stage[i] and v[i] take the values of stage[i-1] and v[i-1].
- EN=0: all stages, valids and CNT hold. D and DV are ignored.
- Q and QV are driven straight from the register of the last stage (registered outputs, no combinational path from D).
- CNT tracks the valid stages:
  - Next value is CNT + DV − v[DEPTH-1] on an advance.
  - It is 0 on clear or reset, and unchanged on hold.
  - CNT must always equal popcount(v); the bench asserts this every cycle.
- Saturation: CNT never exceeds DEPTH. Advancing while full with DV=1 and QV=1 leaves CNT = DEPTH.
- DEPTH=1: behaves as a single WIDTH-bit register with valid; CNT is 1 bit wide.
- Valid data is never dropped or duplicated. Each DV=1 beat appears exactly once on Q/QV after exactly DEPTH advances.

## Timing
- Latency is DEPTH advancing edges, counted in EN=1 cycles rather than clock cycles. With EN held at 1, a beat presented at edge n appears on Q at edge n+DEPTH−1, i.e. it is visible after edge n+DEPTH−1 settles.
- Stall: while EN=0 the pipe is frozen; it resumes with no bubble insertion or loss.
- Clear is effective at the same edge it is sampled. Outputs show the cleared state after that edge.
- Reset asserted mid-stream discards all in-flight beats at once.
- Reset deassertion is assumed synchronised upstream. The first edge with R=0 follows normal priority; if EN=1 and DV=1 at that edge, D is captured.
- EN and CLR asserted together: clear only; the incoming beat is dropped.

## Structure
- Package flop_pkg:
  - Function cnt_w(depth) returning $clog2(depth+1), shared with any future fifo/pipe blocks.
  - Elaboration check that rejects DEPTH < 1 and WIDTH < 1.
- Sub-module flop_stage: one WIDTH-bit data register plus valid bit.
  - Ports CK, R, CLR, EN, D, DV, Q, QV and parameter RST_VAL.
  - Implements the priority and the RST_VAL gating above.
- flop_pipe instantiates DEPTH flop_stage in a generate chain and owns the CNT counter.

## Test plan
- Reset: with WIDTH=8 and RST_VAL=8'hA5, assert R mid-cycle with no clock. Expect Q = A5, QV = 0 and CNT = 0 immediately.
- Streaming: with DEPTH=4, EN=1, drive D = 01, 02, 03 … with DV=1. Expect Q = 01 with QV=1 after the 4th edge, then one value per edge, and CNT to saturate at 4.
- Stall and bubbles:
  - Send 11, a DV=0 bubble, 22, then hold EN=0 for 3 cycles.
  - Expect Q/QV unchanged during the stall.
  - After EN=1, expect 11, a bubble carrying RST_VAL with QV=0, then 22.
  - CNT must equal popcount(v) throughout.
- Clear priority: fill the pipe (CNT=4), then assert CLR and EN with D=FF, DV=1 at the same edge. Expect CNT = 0, QV = 0, Q = RST_VAL, and FF never appears at Q.
- Reset mid-stream: assert R with 3 beats in flight, deassert, then resume. Expect no pre-reset beat ever on Q, and correct latency for new beats.
- DEPTH=1, WIDTH=1 corner: D toggles each edge with DV=1 and EN=1. Expect Q to follow D with a 1-edge delay and CNT to stay 1.
